// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared sizes and helpers for pipe_reg_chain.
// Provides default WIDTH/DEPTH, occupancy width and even parity.
package pipe_reg_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_DEPTH = 3;
    localparam int PAR_MAX_W = 256;

    // Width of a counter able to hold 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Even parity bit: makes the total count of ones even.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one elastic stage, a valid flop plus a W-bit data flop.
// Ports: clk, rst (async low), ld_i, flush_i, v_i/d_i in, v_o/d_o out.
module pipe_reg_stage #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic         flush_i,
    input  logic         v_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);

    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    // Data only captures real words, so a stalled or flushed
    // stage never changes its data register.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (ld_i) begin
            v_d = v_i;
            if (v_i) begin
                d_d = d_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic register chain with flush/occupancy.
// Ports: clk, rst (async low), in_data/in_valid/in_ready, out_data/
// out_valid/out_ready, flush, occupancy; parity_err when
// PIPE_REG_CHAIN_PARITY_EN is defined (adds a parity bit per stage).
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [occ_w(DEPTH)-1:0]  occupancy
`ifdef PIPE_REG_CHAIN_PARITY_EN
    ,
    output logic                     parity_err
`endif
);

`ifdef PIPE_REG_CHAIN_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int SW = WIDTH + PW;
    localparam int OW = occ_w(DEPTH);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] ld;
    logic [DEPTH-1:0] up_v;
    logic [SW-1:0]    d_q  [DEPTH];
    logic [SW-1:0]    up_d [DEPTH];
    logic [SW-1:0]    in_word;

`ifdef PIPE_REG_CHAIN_PARITY_EN
    assign in_word = {even_par(PAR_MAX_W'(in_data)), in_data};
`else
    assign in_word = in_data;
`endif

    // Stage i can load when the downstream end drains or any stage
    // at or after i is empty; this is what collapses bubbles.
    always_comb begin
        logic acc;
        acc = out_ready;
        ld  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc   = acc | ~v_q[i];
            ld[i] = acc;
        end
    end

    assign in_ready = ~flush & ld[0];

    always_comb begin
        up_v[0] = in_valid & in_ready;
        up_d[0] = in_word;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_reg_stage #(
            .W(SW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .ld_i   (ld[g]),
            .flush_i(flush),
            .v_i    (up_v[g]),
            .d_i    (up_d[g]),
            .v_o    (v_q[g]),
            .d_o    (d_q[g])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OW'(v_q[i]);
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1][WIDTH-1:0];

`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic perr_q, perr_d, mism;

    assign mism = out_valid &
                  (even_par(PAR_MAX_W'(out_data)) != d_q[DEPTH-1][WIDTH]);

    always_comb begin
        perr_d = perr_q | mism;
        if (flush) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: randomized self-checking bench for pipe_reg_chain.
// Covers a 10x3 chain against a slot model and a 16x1 chain.
module tb_pipe_reg_chain;
    import pipe_reg_pkg::*;

    localparam int W0 = 10;
    localparam int D0 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W0-1:0] in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready, flush;
    logic [1:0]    occupancy;

    logic [15:0]   in_data1, out_data1;
    logic          in_valid1, in_ready1, out_valid1, out_ready1, flush1;
    logic [0:0]    occupancy1;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic          perr0, perr1;
`endif

    int checks = 0;
    int passed = 0;

    pipe_reg_chain #(.WIDTH(W0), .DEPTH(D0)) u0 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .occupancy(occupancy)
`ifdef PIPE_REG_CHAIN_PARITY_EN
        , .parity_err(perr0)
`endif
    );

    pipe_reg_chain #(.WIDTH(16), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .flush(flush1), .occupancy(occupancy1)
`ifdef PIPE_REG_CHAIN_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    // Reference: slots numbered toward the output; each edge, words
    // slide forward into any free slot, the last leaves on out_ready.
    bit            mvv [D0];
    logic [W0-1:0] md  [D0];

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < D0; i++) c += int'(mvv[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D0; i++) begin
            mvv[i] = 1'b0;
            md[i]  = '0;
        end
    endtask

    task automatic model_step(input bit iv, input logic [W0-1:0] id,
                              input bit ordy, input bit fl);
        bit            nv [D0];
        logic [W0-1:0] nd [D0];
        for (int i = 0; i < D0; i++) begin
            nv[i] = 1'b0;
            nd[i] = md[i];
        end
        if (fl) begin
            for (int i = 0; i < D0; i++) mvv[i] = 1'b0;
            return;
        end
        if (mvv[D0-1] && !ordy) nv[D0-1] = 1'b1;
        for (int i = D0 - 2; i >= 0; i--) begin
            if (mvv[i]) begin
                if (!nv[i+1]) begin
                    nv[i+1] = 1'b1;
                    nd[i+1] = md[i];
                end else begin
                    nv[i] = 1'b1;
                end
            end
        end
        if (iv && !nv[0]) begin
            nv[0] = 1'b1;
            nd[0] = id;
        end
        mvv = nv;
        md  = nd;
    endtask

    function automatic bit exp_rdy();
        return !flush && (out_ready || mcount() < D0);
    endfunction

    task automatic drive(input bit iv, input logic [W0-1:0] id,
                         input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(in_valid, in_data, out_ready, flush);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rst.out_valid got=%b exp=0", out_valid);
        else passed++;
        checks++;
        if (out_data !== '0) $display("FAIL rst.out_data got=%h exp=0", out_data);
        else passed++;
        checks++;
        if (occupancy !== 2'd0) $display("FAIL rst.occ got=%0d exp=0", occupancy);
        else passed++;
        checks++;
        if (out_valid1 !== 1'b0) $display("FAIL rst.out_valid1 got=%b exp=0", out_valid1);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL rst.in_ready got=%b exp=1", in_ready);
        else passed++;
        checks++;
        if (in_ready1 !== 1'b1) $display("FAIL rst.in_ready1 got=%b exp=1", in_ready1);
        else passed++;
    endtask

    task automatic check_cycle(input string tag, input int c);
        checks++;
        if (in_ready !== exp_rdy())
            $display("FAIL %s.in_ready c=%0d got=%b exp=%b", tag, c, in_ready, exp_rdy());
        else passed++;
        checks++;
        if (out_valid !== mvv[D0-1])
            $display("FAIL %s.out_valid c=%0d got=%b exp=%b", tag, c, out_valid, mvv[D0-1]);
        else passed++;
        if (mvv[D0-1]) begin
            checks++;
            if (out_data !== md[D0-1])
                $display("FAIL %s.out_data c=%0d got=%h exp=%h", tag, c, out_data, md[D0-1]);
            else passed++;
        end
        checks++;
        if (occupancy !== 2'(mcount()))
            $display("FAIL %s.occ c=%0d got=%0d exp=%0d", tag, c, occupancy, mcount());
        else passed++;
    endtask

    task automatic test_stream();
        logic [W0-1:0] words [6];
        logic [W0-1:0] got [$];
        int first_out = -1;
        words = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h3E0, 10'h01F};
        for (int c = 0; c < 10; c++) begin
            if (c < 6) drive(1'b1, words[c], 1'b1, 1'b0);
            else drive(1'b0, '0, 1'b1, 1'b0);
            check_cycle("stream", c);
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (first_out < 0) first_out = c;
            end
            advance();
        end
        checks++;
        if (first_out != 3) $display("FAIL stream.latency got=%0d exp=3", first_out);
        else passed++;
        checks++;
        if (got.size() != 6) $display("FAIL stream.count got=%0d exp=6", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++;
            if (got[i] !== words[i])
                $display("FAIL stream.order i=%0d got=%h exp=%h", i, got[i], words[i]);
            else passed++;
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int bad = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 10'h155, 1'b0, 1'b0);
            check_cycle("stall", c);
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check_cycle("drain", c);
            if (out_valid) begin
                n++;
                if (out_data !== 10'h155) bad++;
            end
            advance();
        end
        checks++;
        if (n != 3 || bad != 0)
            $display("FAIL stall.drain got=%0d words (%0d bad) exp=3 words", n, bad);
        else passed++;
    endtask

    task automatic test_random();
        logic [W0-1:0] sent [$];
        logic [W0-1:0] recv [$];
        logic [W0-1:0] prev_d = '0;
        bit            prev_stall = 1'b0;
        int            cyc = 0;
        while (recv.size() < 200 && cyc < 3000) begin
            bit            iv;
            logic [W0-1:0] d;
            iv = (sent.size() < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            d  = W0'($urandom);
            drive(iv, d, ~cyc[0], 1'b0);
            check_cycle("rand", cyc);
            if (prev_stall && out_valid) begin
                checks++;
                if (out_data !== prev_d)
                    $display("FAIL rand.stable c=%0d got=%h exp=%h", cyc, out_data, prev_d);
                else passed++;
            end
            if (iv && exp_rdy()) sent.push_back(d);
            if (out_valid && out_ready) recv.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            advance();
            cyc++;
        end
        checks++;
        if (recv.size() != 200 || sent.size() != 200)
            $display("FAIL rand.count got=%0d recv exp=200 (sent %0d, cyc %0d)",
                     recv.size(), sent.size(), cyc);
        else passed++;
        for (int i = 0; i < recv.size() && i < sent.size(); i++) begin
            checks++;
            if (recv[i] !== sent[i])
                $display("FAIL rand.order i=%0d got=%h exp=%h", i, recv[i], sent[i]);
            else passed++;
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 10'h3E0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 10'h01F, 1'b0, 1'b1);
        check_cycle("flush", 0);
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd0) $display("FAIL flush.occ got=%0d exp=0", occupancy);
        else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL flush.out_valid got=%b exp=0", out_valid);
        else passed++;
        checks++;
        if (out_data !== 10'h3E0) $display("FAIL flush.data_kept got=%h exp=3e0", out_data);
        else passed++;
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check_cycle("postflush", c);
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 10'h2AA, 1'b0, 1'b0);
        advance();
        drive(1'b1, 10'h155, 1'b0, 1'b0);
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        check_cycle("premid", 0);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL midrst.out_valid got=%b exp=0", out_valid);
        else passed++;
        checks++;
        if (out_data !== '0) $display("FAIL midrst.out_data got=%h exp=0", out_data);
        else passed++;
        checks++;
        if (occupancy !== 2'd0) $display("FAIL midrst.occ got=%0d exp=0", occupancy);
        else passed++;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_cycle("postrst", 0);
    endtask

    task automatic test_d1();
        bit          m1v = 1'b0;
        logic [15:0] m1d = '0;
        bit          er;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid1  = (c % 7) != 5;
            in_data1   = (c == 0) ? 16'hBEEF : 16'hBEEF ^ 16'(c * 16'h0111);
            out_ready1 = c[0];
            flush1     = 1'b0;
            #1;
            er = !flush1 && (!m1v || out_ready1);
            checks++;
            if (in_ready1 !== er) $display("FAIL d1.in_ready c=%0d got=%b exp=%b", c, in_ready1, er);
            else passed++;
            checks++;
            if (out_valid1 !== m1v) $display("FAIL d1.out_valid c=%0d got=%b exp=%b", c, out_valid1, m1v);
            else passed++;
            if (m1v) begin
                checks++;
                if (out_data1 !== m1d) $display("FAIL d1.out_data c=%0d got=%h exp=%h", c, out_data1, m1d);
                else passed++;
            end
            if (c == 1) begin
                checks++;
                if (out_data1 !== 16'hBEEF || out_valid1 !== 1'b1)
                    $display("FAIL d1.latency got=%b/%h exp=1/beef", out_valid1, out_data1);
                else passed++;
            end
            checks++;
            if (occupancy1 !== 1'(m1v)) $display("FAIL d1.occ c=%0d got=%0d exp=%0d", c, occupancy1, m1v);
            else passed++;
            @(posedge clk);
            if (m1v && out_ready1) m1v = 1'b0;
            if (in_valid1 && er) begin
                m1v = 1'b1;
                m1d = in_data1;
            end
        end
`ifdef PIPE_REG_CHAIN_PARITY_EN
        @(negedge clk);
        in_valid1  = 1'b1;
        in_data1   = 16'hBEEF;
        out_ready1 = 1'b0;
        @(negedge clk);
        in_valid1 = 1'b0;
        checks++;
        if (perr1 !== 1'b0) $display("FAIL par.clean got=%b exp=0", perr1);
        else passed++;
        checks++;
        if (perr0 !== 1'b0) $display("FAIL par.clean0 got=%b exp=0", perr0);
        else passed++;
        force u1.g_stage[0].u_stage.d_q = 17'h00001;
        @(negedge clk);
        release u1.g_stage[0].u_stage.d_q;
        checks++;
        if (perr1 !== 1'b1) $display("FAIL par.set got=%b exp=1", perr1);
        else passed++;
        out_ready1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (perr1 !== 1'b1) $display("FAIL par.sticky got=%b exp=1", perr1);
        else passed++;
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        checks++;
        if (perr1 !== 1'b0) $display("FAIL par.flush got=%b exp=0", perr1);
        else passed++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        in_data1   = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        flush1     = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_random();
        test_flush();
        test_reset_mid();
        test_d1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised successor to the fixed 10-bit register. It is a DEPTH-stage chain of WIDTH-bit registers with valid/ready handshaking on both ends, bubble collapsing, synchronous flush and an occupancy count. It is used as the standard elastic pipeline/retiming element between lab datapath blocks.

Parameters:
WIDTH, 10, data bits per stage (>=1)
DEPTH, 3, number of register stages (>=1; DEPTH=1 is a single elastic register)

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
in_data  input  WIDTH  upstream data
in_valid  input  1  upstream data valid
in_ready  output  1  chain accepts in_data this cycle
out_data  output  WIDTH  data of last stage
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data this cycle
flush  input  1  synchronous clear of all stage valids
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (rst=0, async): all stage valid bits=0, all stage data=0; out_valid=0, out_data=0, occupancy=0, in_ready=1 once rst=1 (combinational from cleared state).
- Stage i holds {v[i], d[i]}; stage 0 is the input, stage DEPTH-1 drives out_data/out_valid directly from flops (no combinational in->out path).
- Advance rule: adv[DEPTH-1] = out_ready | ~v[DEPTH-1]; adv[i] = adv[i+1] | ~v[i+1] ... precisely: stage i may load when ~v[i] | move[i], where move[i] = v[i] & (stage i+1 loads), move[DEPTH-1] = v[DEPTH-1] & out_ready.
- in_ready = ~flush & (~v[0] | move[0]). Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Bubble collapsing: a valid stage advances into an empty downstream stage even when out_ready=0; a stalled chain fills completely (occupancy reaches DEPTH) before in_ready drops.
- Latency: empty chain, no stall: data accepted at edge N appears on out_data with out_valid=1 after edge N+DEPTH-1 (DEPTH cycles from in_valid to out_valid). Full throughput is 1 word/cycle.
- Data of an invalid stage is don't-care but must not change while that stage is stalled and valid (stable under out_valid & ~out_ready).
- occupancy = popcount of v[]; updates the same edge as the valids; never exceeds DEPTH.
- Simultaneous in and out transfer on full chain: occupancy unchanged, all stages shift.
- flush=1: at next edge all v[]=0, data registers unchanged; in_ready=0 during flush, so any in_valid that cycle is dropped; out transfer in a flush cycle still counts as consumed downstream (out_valid remains combinationally from flops that cycle).
- rst asserted mid-transfer: state cleared immediately, in-flight words lost, no partial output.

Optional Feature:
PIPE_REG_CHAIN_PARITY_EN: when defined, each stage carries an extra even-parity bit computed from in_data on entry; the last stage recomputes parity and a sticky output parity_err (1 bit, reset 0, cleared only by rst or flush) sets on the edge after a mismatching word is presented with out_valid=1. Without the macro: no parity bits, no parity_err port; area = WIDTH*DEPTH+DEPTH flops.

Decomposition:
- Package pipe_reg_pkg: function for occupancy width (clog2(DEPTH+1)), default WIDTH/DEPTH constants, parity helper function.
- Sub-module pipe_reg_stage (one stage: valid+data flops, load enable, flush, async active-low reset) instantiated DEPTH times via generate; top holds move/ready chain and popcount.

Test Plan:
- Reset then stream 10'h3FF,10'h000,10'h155,10'h2AA,10'h3E0,10'h01F with out_ready=1 -> same sequence out in order, first out_valid 3 cycles after first in_valid, one word/cycle, occupancy steady at 3.
- out_ready=0, push 10'h155 continuously -> occupancy 1,2,3 then in_ready=0; release out_ready -> 3 words of 10'h155 drain with no loss/duplication.
- Alternating out_ready 1/0 with random in_valid, 200 words -> output sequence equals input sequence (scoreboard), out_data stable during stalls.
- Chain full (10'h3E0 x3), assert flush with in_valid=1, in_data=10'h01F -> next cycle occupancy=0, out_valid=0, 10'h01F never appears.
- Assert rst low mid-stream with 2 words in flight -> out_valid=0, out_data=0, occupancy=0 immediately (before next edge).
- DEPTH=1, WIDTH=16 instance: 16'hBEEF in, out_ready toggling -> 1-cycle latency, full throughput when out_ready=1; with parity macro, corrupt stage data via force -> parity_err=1 next edge, sticky until flush.
